diram_chan_responder: RTL and testbench

- Synthesizable single-clock DIRAM channel model; the PHY-side end of the dfi→phy interface.
- Decodes cs/cmd1/cmd0/bank/addr/data from the DFI and tracks the open page per bank.
- Stores write bursts and returns read bursts on phy__dfi__data/phy__dfi__data_valid after a fixed read latency.
- Used in manager sim/emulation in place of the DRAM macro; one instance per channel.

---
 rtl/diram_chan_responder_pkg.sv | 19 +
 rtl/diram_chan_rd_pipe.sv | 81 ++++++++
 rtl/diram_chan_responder.sv | 176 +++++++++++++++++
 tb/tb_diram_chan_responder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/diram_chan_responder_pkg.sv
// Shared DFI definitions: command encoding and default bank/address widths
// used by the DFI side and the DIRAM channel responder.
package diram_chan_responder_pkg;

  localparam int DFI_BANK_WIDTH = 2;
  localparam int DFI_ADDR_WIDTH = 12;

  typedef enum logic [1:0] {
    CMD_NOP = 2'b00,
    CMD_ACT = 2'b01,
    CMD_WR  = 2'b10,
    CMD_RD  = 2'b11
  } dfi_cmd_e;

  function automatic logic is_access(input dfi_cmd_e c);
    return (c == CMD_WR) || (c == CMD_RD);
  endfunction

endpackage

// File: rtl/diram_chan_rd_pipe.sv
// Read-latency pipe of {valid, array index} followed by a burst beat counter
// that walks the column field (wrapping inside the page) for each burst.
module diram_chan_rd_pipe
  import diram_chan_responder_pkg::*;
#(
  parameter int IDX_W     = 9,
  parameter int COL_BITS  = 4,
  parameter int RD_LAT    = 4,
  parameter int BURST_LEN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [IDX_W-1:0] push_idx,
  output logic             busy,
  output logic             beat_vld,
  output logic [IDX_W-1:0] beat_idx
);

  localparam int BL_W = $clog2(BURST_LEN + 1);

  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [IDX_W-1:0]  idx_q [RD_LAT];
  logic [IDX_W-1:0]  idx_d [RD_LAT];
  logic [BL_W-1:0]   beat_left_q, beat_left_d;
  logic [BL_W-1:0]   gap_q, gap_d;
  logic [IDX_W-1:0]  cur_idx_q, cur_idx_d;
  logic              pipe_out;

  function automatic logic [IDX_W-1:0] col_inc(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] r;
    r = idx;
    r[COL_BITS-1:0] = idx[COL_BITS-1:0] + COL_BITS'(1);
    return r;
  endfunction

  assign pipe_out = vld_q[RD_LAT-1];
  assign beat_vld = pipe_out || (beat_left_q != '0);
  assign beat_idx = pipe_out ? idx_q[RD_LAT-1] : cur_idx_q;
  // A new RD may only start once the previous burst's window has slid past.
  assign busy     = (gap_q != '0);

  always_comb begin
    vld_d[0] = push;
    idx_d[0] = push_idx;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      idx_d[i] = idx_q[i-1];
    end
    beat_left_d = beat_left_q;
    cur_idx_d   = cur_idx_q;
    if (pipe_out) begin
      beat_left_d = BL_W'(BURST_LEN - 1);
      cur_idx_d   = col_inc(idx_q[RD_LAT-1]);
    end else if (beat_left_q != '0) begin
      beat_left_d = beat_left_q - BL_W'(1);
      cur_idx_d   = col_inc(cur_idx_q);
    end
    gap_d = gap_q;
    if (push)               gap_d = BL_W'(BURST_LEN - 1);
    else if (gap_q != '0)   gap_d = gap_q - BL_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q       <= '0;
      beat_left_q <= '0;
      gap_q       <= '0;
    end else begin
      vld_q       <= vld_d;
      beat_left_q <= beat_left_d;
      gap_q       <= gap_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < RD_LAT; i++) idx_q[i] <= idx_d[i];
    cur_idx_q <= cur_idx_d;
  end

endmodule

// File: rtl/diram_chan_responder.sv
// PHY-side DIRAM channel model: decodes DFI commands, tracks open pages, stores
// write bursts and returns read bursts. Optional ACT->RD/WR spacing check under
// `DIRAM_CHAN_RESPONDER_TRCD_CHECK_EN.
module diram_chan_responder
  import diram_chan_responder_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int BANK_WIDTH  = DFI_BANK_WIDTH,
  parameter int ADDR_WIDTH  = DFI_ADDR_WIDTH,
  parameter int COL_BITS    = 4,
  parameter int PAGE_BITS   = 3,
  parameter int BURST_LEN   = 2,
  parameter int RD_LAT      = 4,
  parameter int INIT_CYCLES = 8,
  parameter int TRCD        = 3
) (
  input  logic                  clk,
  input  logic                  reset_poweron,
  input  logic                  dfi__phy__cs,
  input  logic                  dfi__phy__cmd1,
  input  logic                  dfi__phy__cmd0,
  input  logic [BANK_WIDTH-1:0] dfi__phy__bank,
  input  logic [ADDR_WIDTH-1:0] dfi__phy__addr,
  input  logic [DATA_WIDTH-1:0] dfi__phy__data,
  output logic                  phy__dfi__data_valid,
  output logic [DATA_WIDTH-1:0] phy__dfi__data,
  output logic                  phy__dfi__init_done,
  output logic                  phy__dfi__error
);

  localparam int IDX_W  = BANK_WIDTH + PAGE_BITS + COL_BITS;
  localparam int NBANK  = 1 << BANK_WIDTH;
  localparam int DEPTH  = 1 << IDX_W;
  localparam int INIT_W = $clog2(INIT_CYCLES + 1);
  localparam int BL_W   = $clog2(BURST_LEN + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PAGE_BITS-1:0]  page_q [NBANK];
  logic [NBANK-1:0]      open_q, open_d;
  logic [INIT_W-1:0]     init_cnt_q, init_cnt_d;
  logic                  init_done_q, init_done_d;
  logic                  error_q, error_d;
  logic [BL_W-1:0]       wr_left_q, wr_left_d;
  logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  dfi_cmd_e              cmd;
  logic [IDX_W-1:0]      cmd_idx, waddr, beat_idx;
  logic                  act_ok, wr_ok, rd_ok, err_set, we, rd_busy, beat_vld, trcd_hit;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  unused_cfg;

  assign cmd     = dfi_cmd_e'({dfi__phy__cmd1, dfi__phy__cmd0});
  assign cmd_idx = {dfi__phy__bank, page_q[dfi__phy__bank], dfi__phy__addr[COL_BITS-1:0]};
  assign unused_cfg = ^{dfi__phy__addr, 1'(TRCD)};

  always_comb begin
    act_ok  = 1'b0;
    wr_ok   = 1'b0;
    rd_ok   = 1'b0;
    err_set = 1'b0;
    if (dfi__phy__cs) begin
      if (!init_done_q) begin
        err_set = 1'b1;
      end else if (wr_left_q != '0) begin
        err_set = (cmd != CMD_NOP);
      end else if (is_access(cmd) && !open_q[dfi__phy__bank]) begin
        err_set = 1'b1;
      end else begin
        case (cmd)
          CMD_ACT: act_ok = 1'b1;
          CMD_WR:  wr_ok  = 1'b1;
          CMD_RD:  if (rd_busy) err_set = 1'b1; else rd_ok = 1'b1;
          default: ;
        endcase
      end
    end
    // Spacing violations are flagged but the access still goes ahead.
    if ((wr_ok || rd_ok) && trcd_hit) err_set = 1'b1;
  end

  always_comb begin
    open_d = open_q;
    if (act_ok) open_d[dfi__phy__bank] = 1'b1;
    init_cnt_d  = init_done_q ? init_cnt_q : init_cnt_q + INIT_W'(1);
    init_done_d = init_done_q || (init_cnt_d == INIT_W'(INIT_CYCLES));
    error_d     = error_q || err_set;

    we    = wr_ok || (wr_left_q != '0);
    waddr = wr_ok ? cmd_idx : wr_idx_q;
    wr_idx_d = waddr;
    wr_idx_d[COL_BITS-1:0] = waddr[COL_BITS-1:0] + COL_BITS'(1);
    wr_left_d = wr_left_q;
    if (wr_ok)                wr_left_d = BL_W'(BURST_LEN - 1);
    else if (wr_left_q != '0) wr_left_d = wr_left_q - BL_W'(1);

    // Write-first: a beat read in the same cycle as its write sees the new word.
    rd_word = (we && (waddr == beat_idx)) ? dfi__phy__data : mem[beat_idx];
    valid_d = beat_vld;
    data_d  = beat_vld ? rd_word : data_q;
  end

`ifdef DIRAM_CHAN_RESPONDER_TRCD_CHECK_EN
  localparam int TW = $clog2(TRCD + 1);
  logic [TW-1:0] trcd_q [NBANK];
  logic [TW-1:0] trcd_d [NBANK];

  assign trcd_hit = (trcd_q[dfi__phy__bank] != '0);

  // Loaded with TRCD-1 so an access exactly TRCD cycles after ACT is clean.
  always_comb begin
    for (int b = 0; b < NBANK; b++) begin
      trcd_d[b] = (trcd_q[b] != '0) ? trcd_q[b] - TW'(1) : trcd_q[b];
      if (act_ok && (dfi__phy__bank == BANK_WIDTH'(b))) trcd_d[b] = TW'(TRCD - 1);
    end
  end

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      for (int b = 0; b < NBANK; b++) trcd_q[b] <= '0;
    end else begin
      for (int b = 0; b < NBANK; b++) trcd_q[b] <= trcd_d[b];
    end
  end
`else
  assign trcd_hit = 1'b0;
`endif

  diram_chan_rd_pipe #(
    .IDX_W    (IDX_W),
    .COL_BITS (COL_BITS),
    .RD_LAT   (RD_LAT),
    .BURST_LEN(BURST_LEN)
  ) u_rd_pipe (
    .clk     (clk),
    .rst     (reset_poweron),
    .push    (rd_ok),
    .push_idx(cmd_idx),
    .busy    (rd_busy),
    .beat_vld(beat_vld),
    .beat_idx(beat_idx)
  );

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      open_q      <= '0;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      error_q     <= 1'b0;
      wr_left_q   <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
    end else begin
      open_q      <= open_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      error_q     <= error_d;
      wr_left_q   <= wr_left_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    wr_idx_q <= wr_idx_d;
    if (act_ok) page_q[dfi__phy__bank] <= dfi__phy__addr[PAGE_BITS-1:0];
    if (we) mem[waddr] <= dfi__phy__data;
  end

  assign phy__dfi__data_valid = valid_q;
  assign phy__dfi__data       = data_q;
  assign phy__dfi__init_done  = init_done_q;
  assign phy__dfi__error      = error_q;

endmodule

// File: tb/tb_diram_chan_responder.sv
// Scoreboard bench for diram_chan_responder: expected read beats (data and
// arrival cycle) are queued when RDs are issued and checked as they emerge.
module tb_diram_chan_responder;

  localparam int RL = 4;
  localparam logic [1:0] NOP = 2'b00, ACT = 2'b01, WR = 2'b10, RD = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0, cmd1 = 1'b0, cmd0 = 1'b0;
  logic [1:0]  bank = '0;
  logic [11:0] addr = '0;
  logic [31:0] wdat = '0;
  logic        vld, init_done, err;
  logic [31:0] rdat;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          cyc;
    logic [31:0] d;
  } exp_t;
  exp_t exp_q[$];

  diram_chan_responder dut (
    .clk                 (clk),
    .reset_poweron       (rst),
    .dfi__phy__cs        (cs),
    .dfi__phy__cmd1      (cmd1),
    .dfi__phy__cmd0      (cmd0),
    .dfi__phy__bank      (bank),
    .dfi__phy__addr      (addr),
    .dfi__phy__data      (wdat),
    .phy__dfi__data_valid(vld),
    .phy__dfi__data      (rdat),
    .phy__dfi__init_done (init_done),
    .phy__dfi__error     (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && vld) begin
      if (exp_q.size() == 0) begin
        chk("unexp_vld", 32'(vld), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rd_data", rdat, e.d);
        chk("rd_cyc", cyc, e.cyc);
      end
    end
  end

  task automatic drive(input logic c_s, input logic [1:0] c, input logic [1:0] b,
                       input logic [11:0] a, input logic [31:0] d);
    cs = c_s; {cmd1, cmd0} = c; bank = b; addr = a; wdat = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, NOP, 2'd0, 12'd0, 32'd0);
  endtask

  task automatic wr2(input logic [1:0] b, input logic [11:0] col, input logic [31:0] d0, input logic [31:0] d1);
    drive(1'b1, WR, b, col, d0);
    drive(1'b0, NOP, 2'd0, 12'd0, d1);
  endtask

  task automatic rd2(input logic [1:0] b, input logic [11:0] col, input logic [31:0] d0, input logic [31:0] d1);
    exp_q.push_back('{cyc + 1 + RL, d0});
    exp_q.push_back('{cyc + 2 + RL, d1});
    drive(1'b1, RD, b, col, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; cs = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_vld", 32'(vld), 32'd0);
    chk("rst_data", rdat, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_init", 32'(init_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // Command during init, then init_done rising on cycle 8.
    idle(2);
    drive(1'b1, ACT, 2'd0, 12'd0, 32'd0);
    chk("init_err", 32'(err), 32'd1);
    chk("init_early", 32'(init_done), 32'd0);
    idle(4);
    chk("init_c7", 32'(init_done), 32'd0);
    idle(1);
    chk("init_c8", 32'(init_done), 32'd1);
    chk("init_err_sticky", 32'(err), 32'd1);

    // Basic write then read-after-write.
    do_reset();
    idle(10);
    drive(1'b1, ACT, 2'd1, 12'd5, 32'd0);
    wr2(2'd1, 12'd2, 32'hA5A5_0001, 32'hA5A5_0002);
    rd2(2'd1, 12'd2, 32'hA5A5_0001, 32'hA5A5_0002);
    idle(8);
    chk("basic_err", 32'(err), 32'd0);

    // Column wrap stays inside the page; neighbouring page untouched.
    drive(1'b1, ACT, 2'd0, 12'd4, 32'd0);
    wr2(2'd0, 12'd15, 32'h4444_000F, 32'h4444_0000);
    drive(1'b1, ACT, 2'd0, 12'd3, 32'd0);
    wr2(2'd0, 12'd15, 32'h3333_000F, 32'h3333_0000);
    rd2(2'd0, 12'd15, 32'h3333_000F, 32'h3333_0000);
    idle(6);
    drive(1'b1, ACT, 2'd0, 12'd4, 32'd0);
    rd2(2'd0, 12'd15, 32'h4444_000F, 32'h4444_0000);
    idle(8);
    chk("wrap_err", 32'(err), 32'd0);

    // Back-to-back RDs exactly BURST_LEN apart give four gapless beats.
    rd2(2'd1, 12'd2, 32'hA5A5_0001, 32'hA5A5_0002);
    idle(1);
    rd2(2'd1, 12'd2, 32'hA5A5_0001, 32'hA5A5_0002);
    idle(8);
    chk("b2b_err", 32'(err), 32'd0);
    chk("b2b_drained", exp_q.size(), 32'd0);

    // Overlapping RD one cycle later is dropped.
    rd2(2'd1, 12'd2, 32'hA5A5_0001, 32'hA5A5_0002);
    drive(1'b1, RD, 2'd1, 12'd2, 32'd0);
    chk("overlap_err", 32'(err), 32'd1);
    idle(10);

    // RD to a never-activated bank.
    do_reset();
    idle(10);
    drive(1'b1, RD, 2'd3, 12'd0, 32'd0);
    chk("closed_err", 32'(err), 32'd1);
    idle(10);

    // Reset mid read burst: valid drops at once.
    do_reset();
    idle(10);
    drive(1'b1, ACT, 2'd1, 12'd5, 32'd0);
    rd2(2'd1, 12'd2, 32'hA5A5_0001, 32'hA5A5_0002);
    idle(4);
    #1;
    chk("beat0_seen", exp_q.size(), 32'd1);
    do_reset();

    // Reset mid write burst keeps the beat already written.
    idle(10);
    drive(1'b1, ACT, 2'd1, 12'd5, 32'd0);
    drive(1'b1, WR, 2'd1, 12'd2, 32'hBEEF_0001);
    do_reset();
    idle(10);
    drive(1'b1, ACT, 2'd1, 12'd5, 32'd0);
    rd2(2'd1, 12'd2, 32'hBEEF_0001, 32'hA5A5_0002);
    idle(8);
    chk("partial_err", 32'(err), 32'd0);

`ifdef DIRAM_CHAN_RESPONDER_TRCD_CHECK_EN
    // ACT->RD spacing: too early flags but still reads; TRCD apart is clean.
    do_reset();
    idle(10);
    drive(1'b1, ACT, 2'd2, 12'd1, 32'd0);
    idle(3);
    wr2(2'd2, 12'd0, 32'hC0C0_0000, 32'hC0C0_0001);
    idle(2);
    chk("trcd_pre_err", 32'(err), 32'd0);
    drive(1'b1, ACT, 2'd2, 12'd1, 32'd0);
    rd2(2'd2, 12'd0, 32'hC0C0_0000, 32'hC0C0_0001);
    chk("trcd_err", 32'(err), 32'd1);
    idle(8);
    do_reset();
    idle(10);
    drive(1'b1, ACT, 2'd2, 12'd1, 32'd0);
    idle(2);
    rd2(2'd2, 12'd0, 32'hC0C0_0000, 32'hC0C0_0001);
    idle(8);
    chk("trcd_ok_err", 32'(err), 32'd0);
`endif

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
